// File: rtl/clock_gating_model.sv
// Integrated clock-gating cell: a low-transparent enable latch followed by an AND,
// with a test bypass, a latched-enable status output and a gated-edge counter.
module clock_gating_model #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clock_en,
  input  logic             i_test_en,
  output logic             o_clk,
  output logic             o_en_latched,
  output logic [CNT_W-1:0] o_edge_cnt
);

  logic             en_d;
  logic             en_latch_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  assign en_d = i_clock_en | i_test_en;

  // The latch is closed while i_clk is high, so enable edges during the high
  // phase cannot reach the AND gate and cut a pulse short.
  // NOTE: latches are written with non-blocking assignments, like flops, so
  // readers of en_latch_q in the same time step see a consistent value.
  always_latch begin
    if (i_rst) begin
      en_latch_q <= 1'b0;
    end else if (!i_clk) begin
      en_latch_q <= en_d;
    end
  end

  assign o_clk        = i_clk & en_latch_q;
  assign o_en_latched = en_latch_q;

  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge o_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_edge_cnt = cnt_q;

endmodule

// File: tb/tb_clock_gating_model.sv
// Directed bench for clock_gating_model: a queue holds the expected gating of each
// rising edge, pushed when the low-phase enable is driven and popped at the edge.
module tb_clock_gating_model;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_clock_en = 1'b0;
  logic        i_test_en = 1'b0;
  logic        o_clk16, o_en16;
  logic        o_clk4, o_en4;
  logic [15:0] o_cnt16;
  logic [3:0]  o_cnt4;

  int          passed = 0;
  int          total = 0;
  int          model_cnt = 0;
  logic        exp_q[$];

  clock_gating_model u_dut16 (
    .i_clk(i_clk), .i_rst(i_rst), .i_clock_en(i_clock_en), .i_test_en(i_test_en),
    .o_clk(o_clk16), .o_en_latched(o_en16), .o_edge_cnt(o_cnt16)
  );

  clock_gating_model #(.CNT_W(4)) u_dut4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_clock_en(i_clock_en), .i_test_en(i_test_en),
    .o_clk(o_clk4), .o_en_latched(o_en4), .o_edge_cnt(o_cnt4)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input logic clk_e, input logic en_e);
    check({tag, " o_clk"}, {31'd0, o_clk16}, {31'd0, clk_e});
    check({tag, " o_clk4"}, {31'd0, o_clk4}, {31'd0, clk_e});
    check({tag, " en"}, {31'd0, o_en16}, {31'd0, en_e});
    check({tag, " en4"}, {31'd0, o_en4}, {31'd0, en_e});
    check({tag, " cnt16"}, {16'd0, o_cnt16}, model_cnt & 32'hFFFF);
    check({tag, " cnt4"}, {28'd0, o_cnt4}, model_cnt & 32'hF);
  endtask

  // One i_clk period: drive the low-phase enable, check the rising edge it gates,
  // then move i_clock_en to hi_en mid-high-phase and confirm the pulse is intact.
  task automatic step(input string tag, input logic en, input logic te, input logic hi_en);
    logic e;
    @(negedge i_clk);
    #1;
    i_clock_en = en;
    i_test_en  = te;
    exp_q.push_back(en | te);
    #1;
    check_all({tag, " low"}, 1'b0, en | te);
    @(posedge i_clk);
    #1;
    e = exp_q.pop_front();
    if (e) model_cnt++;
    check_all({tag, " rise"}, e, e);
    #1;
    i_clock_en = hi_en;
    #2;
    check_all({tag, " late-high"}, e, e);
  endtask

  initial begin
    // Reset held across two periods with the enable up.
    i_clock_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #4;
      check_all("reset", 1'b0, 1'b0);
      #1;
    end
    @(negedge i_clk);
    #1;
    i_rst = 1'b0;
    i_clock_en = 1'b0;

    // Enable window: idle, ten enabled periods, idle.
    for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("window", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("off", 1'b0, 1'b0, 1'b0);
    check("window count", {16'd0, o_cnt16}, 32'd10);

    // Glitch: raise mid-high (no pulse until next edge), drop mid-high (pulse completes).
    step("glitch-rise", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("glitch-on", 1'b1, 1'b0, 1'b1);
    step("glitch-fall", 1'b1, 1'b0, 1'b0);
    step("glitch-after", 1'b0, 1'b0, 1'b0);

    // Test bypass with the functional enable low.
    for (int i = 0; i < 5; i++) step("bypass", 1'b0, 1'b1, 1'b0);
    step("bypass-off", 1'b0, 1'b0, 1'b0);

    // Mid-pulse reset, released while i_clk is still high.
    step("pre-rst", 1'b1, 1'b0, 1'b1);
    step("pre-rst", 1'b1, 1'b0, 1'b1);
    @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    model_cnt = 0;
    #1;
    check_all("mid-rst", 1'b0, 1'b0);
    i_rst = 1'b0;
    #1;
    check_all("rst-released-high", 1'b0, 1'b0);

    // Resume, then wrap the 4-bit counter: 17 pulses since reset.
    for (int i = 0; i < 15; i++) step("wrap", 1'b1, 1'b0, 1'b1);
    check("wrap at 15", {28'd0, o_cnt4}, 32'd15);
    step("wrap", 1'b1, 1'b0, 1'b1);
    check("wrap at 16", {28'd0, o_cnt4}, 32'd0);
    step("wrap", 1'b1, 1'b0, 1'b1);
    check("wrap at 17", {28'd0, o_cnt4}, 32'd1);
    check("cnt16 at 17", {16'd0, o_cnt16}, 32'd17);
    step("final", 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
